// File: rtl/io_chan_ctrl.sv
// io_chan_ctrl: per-channel input holding registers and output FIFOs
// between the processor I/O strobes and streaming peripherals.
module io_chan_ctrl #(
    parameter int NUIOIN = 4,
    parameter int NUIOOU = 4,
    parameter int NBIN   = 16,
    parameter int NBOUT  = 33,
    parameter int ODEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUIOIN*NBIN-1:0]  src_data,
    input  logic [NUIOIN-1:0]       src_valid,
    output logic [NUIOIN-1:0]       src_ready,
    input  logic [NUIOIN-1:0]       req_in,
    output logic [NBIN-1:0]         io_in,
    input  logic [NBOUT-1:0]        io_out,
    input  logic [NUIOOU-1:0]       out_en,
    output logic [NUIOOU*NBOUT-1:0] snk_data,
    output logic [NUIOOU-1:0]       snk_valid,
    input  logic [NUIOOU-1:0]       snk_ready,
    input  logic                    clr_sts,
    output logic [NUIOOU-1:0]       ovf,
    output logic [NUIOIN-1:0]       udf
);

    localparam int AW = (ODEPTH > 1) ? $clog2(ODEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(ODEPTH);

    logic [NUIOIN-1:0] rd;
    logic [NUIOIN-1:0] hold_valid;
    logic [NUIOIN-1:0] load;
    logic [NUIOIN-1:0] udf_evt;
    logic [NBIN-1:0]   hold [NUIOIN];

    logic [NUIOOU-1:0] push;
    logic [NUIOOU-1:0] pop;
    logic [NUIOOU-1:0] ovf_evt;

    // Scan downward so the lowest set request is the one that survives.
    always_comb begin
        rd = '0;
        for (int i = NUIOIN - 1; i >= 0; i--) begin
            if (req_in[i]) begin
                rd    = '0;
                rd[i] = 1'b1;
            end
        end
    end

    always_comb begin
        io_in = '0;
        for (int i = 0; i < NUIOIN; i++) begin
            if (rd[i] && hold_valid[i]) begin
                io_in = hold[i];
            end
        end
    end

    assign src_ready = ~hold_valid | rd;
    assign load      = src_valid & src_ready;
    assign udf_evt   = rd & ~hold_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_valid <= '0;
            for (int i = 0; i < NUIOIN; i++) begin
                hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUIOIN; i++) begin
                if (load[i]) begin
                    hold[i]       <= src_data[i*NBIN +: NBIN];
                    hold_valid[i] <= 1'b1;
                end else if (rd[i]) begin
                    hold_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign push = out_en;
    assign pop  = snk_valid & snk_ready;

    for (genvar k = 0; k < NUIOOU; k++) begin : g_out
        logic [NBOUT-1:0] mem [ODEPTH];
        logic [AW-1:0]    wptr;
        logic [AW-1:0]    rptr;
        logic [CW-1:0]    count;
        logic [CW-1:0]    count_nxt;
        logic             do_push;
        logic             sv_q;

        // A full FIFO still takes a push when the head leaves this cycle.
        assign do_push    = push[k] & ((count != FULL) | pop[k]);
        assign ovf_evt[k] = push[k] & (count == FULL) & ~pop[k];

        always_comb begin
            count_nxt = count;
            if (do_push && !pop[k]) begin
                count_nxt = count + CW'(1);
            end else if (pop[k] && !do_push) begin
                count_nxt = count - CW'(1);
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
                sv_q  <= 1'b0;
            end else begin
                if (do_push) begin
                    wptr <= wptr + AW'(1);
                end
                if (pop[k]) begin
                    rptr <= rptr + AW'(1);
                end
                count <= count_nxt;
                sv_q  <= (count_nxt != '0);
            end
        end

        always_ff @(posedge clk) begin
            if (do_push) begin
                mem[wptr] <= io_out;
            end
        end

        assign snk_valid[k] = sv_q;
        assign snk_data[k*NBOUT +: NBOUT] = sv_q ? mem[rptr] : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= '0;
            udf <= '0;
        end else begin
            ovf <= (ovf & ~{NUIOOU{clr_sts}}) | ovf_evt;
            udf <= (udf & ~{NUIOIN{clr_sts}}) | udf_evt;
        end
    end

endmodule

// File: tb/tb_io_chan_ctrl.sv
// tb_io_chan_ctrl: directed stimulus with expected words queued
// for a monitor that checks io_in reads and sink pops.
module tb_io_chan_ctrl;

    logic        clk;
    logic        rst;
    logic [63:0] src_data;
    logic [3:0]  src_valid;
    logic [3:0]  src_ready;
    logic [3:0]  req_in;
    logic [15:0] io_in;
    logic [32:0] io_out;
    logic [3:0]  out_en;
    logic [131:0] snk_data;
    logic [3:0]  snk_valid;
    logic [3:0]  snk_ready;
    logic        clr_sts;
    logic [3:0]  ovf;
    logic [3:0]  udf;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] iq [$];
    logic [32:0] oq [4][$];

    io_chan_ctrl dut (
        .clk(clk), .rst(rst),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .req_in(req_in), .io_in(io_in),
        .io_out(io_out), .out_en(out_en),
        .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
        .clr_sts(clr_sts), .ovf(ovf), .udf(udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int ch);
        for (int c = 0; c < 12 && snk_valid[ch]; c++) step();
        check($sformatf("drain_done_ch%0d", ch), {63'd0, snk_valid[ch]}, 64'd0);
        check($sformatf("queue_empty_ch%0d", ch), oq[ch].size(), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (req_in != 4'b0) begin
                if (iq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL io_in_unexpected: got %h expected none", io_in);
                end else begin
                    check("io_in", {48'd0, io_in}, {48'd0, iq.pop_front()});
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (snk_valid[k] && snk_ready[k]) begin
                    if (oq[k].size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL snk_unexpected_ch%0d: got %h expected none",
                                 k, snk_data[k*33 +: 33]);
                    end else begin
                        check($sformatf("snk_data_ch%0d", k),
                              {31'd0, snk_data[k*33 +: 33]},
                              {31'd0, oq[k].pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; src_data = '0; src_valid = '0; req_in = '0;
        io_out = '0; out_en = '0; snk_ready = '0; clr_sts = 1'b0;
        step(); step();
        #3 rst = 1'b0;
        #1;
        check("rst_src_ready", {60'd0, src_ready}, 64'hF);
        check("rst_snk_valid", {60'd0, snk_valid}, 64'h0);
        check("rst_ovf", {60'd0, ovf}, 64'h0);
        check("rst_udf", {60'd0, udf}, 64'h0);
        check("rst_io_in", {48'd0, io_in}, 64'h0);
        check("rst_snk_data", {60'd0, snk_data[131:128]}, 64'h0);
        step();
        rst = 1'b1;
        step();

        // single word through channel 2, then an underflowing read
        src_data[47:32] = 16'h1234; src_valid = 4'b0100;
        step();
        src_valid = '0; req_in = 4'b0100; iq.push_back(16'h1234);
        step();
        iq.push_back(16'h0000);
        step();
        req_in = '0;
        check("udf_ch2", {60'd0, udf}, 64'h4);
        check("src_ready_idle", {60'd0, src_ready}, 64'hF);
        clr_sts = 1'b1;
        step();
        clr_sts = 1'b0;
        check("udf_clear", {60'd0, udf}, 64'h0);

        // back-to-back read and load on channel 0
        src_data[15:0] = 16'h0001; src_valid = 4'b0001;
        step();
        src_data[15:0] = 16'h0002; req_in = 4'b0001; iq.push_back(16'h0001);
        #1 check("zb_ready0_a", {63'd0, src_ready[0]}, 64'h1);
        step();
        iq.push_back(16'h0002);
        #1 check("zb_ready0_b", {63'd0, src_ready[0]}, 64'h1);
        step();
        req_in = '0; src_valid = '0;
        check("zb_no_udf", {60'd0, udf}, 64'h0);
        req_in = 4'b0001; iq.push_back(16'h0002);
        step();
        req_in = '0;

        // multi-hot read: lowest index wins, other channel untouched
        src_data[31:16] = 16'hAAAA; src_data[47:32] = 16'hBBBB;
        src_valid = 4'b0110;
        step();
        src_valid = '0; req_in = 4'b0110; iq.push_back(16'hAAAA);
        step();
        req_in = 4'b0100; iq.push_back(16'hBBBB);
        step();
        req_in = '0;
        check("mh_no_udf", {60'd0, udf}, 64'h0);
        check("mh_ready", {60'd0, src_ready}, 64'hF);

        // fill channel 1 past capacity
        for (int i = 1; i <= 5; i++) begin
            out_en = 4'b0010; io_out = 33'(i);
            if (i <= 4) oq[1].push_back(33'(i));
            step();
        end
        out_en = '0;
        check("ovf_ch1", {60'd0, ovf}, 64'h2);
        check("full_valid_ch1", {60'd0, snk_valid}, 64'h2);
        snk_ready = 4'hF;
        drain(1);
        snk_ready = '0;
        clr_sts = 1'b1;
        step();
        clr_sts = 1'b0;
        check("ovf_clear_ch1", {60'd0, ovf}, 64'h0);

        // full channel 3 with simultaneous push and pop
        for (int i = 10; i <= 13; i++) begin
            out_en = 4'b1000; io_out = 33'(i); oq[3].push_back(33'(i));
            step();
        end
        out_en = 4'b1000; io_out = 33'd14; snk_ready = 4'b1000;
        oq[3].push_back(33'd14);
        step();
        out_en = '0; snk_ready = '0;
        check("pushpop_no_ovf", {60'd0, ovf}, 64'h0);
        check("pushpop_valid3", {63'd0, snk_valid[3]}, 64'h1);
        check("pushpop_head3", {31'd0, snk_data[99 +: 33]}, 64'd11);
        snk_ready = 4'b1000;
        drain(3);
        snk_ready = '0;

        // clear racing an overflow on channel 0
        for (int i = 0; i < 5; i++) begin
            out_en = 4'b0001; io_out = {1'b1, 32'(i * 3 + 1)};
            if (i < 4) oq[0].push_back({1'b1, 32'(i * 3 + 1)});
            step();
        end
        out_en = '0;
        check("ovf_ch0", {63'd0, ovf[0]}, 64'h1);
        clr_sts = 1'b1; out_en = 4'b0001; io_out = 33'h1FFFFFFFF;
        step();
        clr_sts = 1'b0; out_en = '0;
        check("ovf_race", {63'd0, ovf[0]}, 64'h1);
        clr_sts = 1'b1;
        step();
        clr_sts = 1'b0;
        check("ovf_cleared", {63'd0, ovf[0]}, 64'h0);
        snk_ready = 4'b0001;
        drain(0);
        snk_ready = '0;

        // broadcast write into channels 0 and 2
        out_en = 4'b0101; io_out = 33'h15555AAAA;
        oq[0].push_back(33'h15555AAAA); oq[2].push_back(33'h15555AAAA);
        step();
        out_en = '0;
        check("bcast_valid", {60'd0, snk_valid}, 64'h5);
        snk_ready = 4'hF;
        drain(0);
        drain(2);
        snk_ready = '0;

        // reset with data buffered on both sides
        out_en = 4'b0100; io_out = 33'd7;
        src_data[63:48] = 16'h7777; src_valid = 4'b1000;
        step();
        out_en = '0; src_valid = '0;
        #3 rst = 1'b0;
        #1;
        check("mid_rst_snk_valid", {60'd0, snk_valid}, 64'h0);
        check("mid_rst_src_ready", {60'd0, src_ready}, 64'hF);
        step();
        rst = 1'b1;
        step();
        req_in = 4'b1000; iq.push_back(16'h0000);
        step();
        req_in = '0;
        check("post_rst_udf3", {60'd0, udf}, 64'h8);
        check("post_rst_snk_valid", {60'd0, snk_valid}, 64'h0);

        check("io_queue_empty", iq.size(), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
